// File: rtl/risc_pkg.sv
// ----------------------------------------------------------------------------
// risc_pkg
// Shared definitions for the 8-bit RISC core front end.
//   state_e       : fetch/decode/execute sequencer states
//   *_MSB/*_LSB   : instruction register field positions (opcode, rd, operand)
//   NOP_INSTR     : value the instruction register holds after reset
// ----------------------------------------------------------------------------
package risc_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4
  } state_e;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 7;
  localparam int OPND_MSB = 6;
  localparam int OPND_LSB = 0;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/instr_fetch_seq_pc_reg.sv
// ----------------------------------------------------------------------------
// pc_reg
// Program counter register with load / increment / hold. Increment wraps
// modulo 2^PC_W with no carry-out.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, loads RESET_VEC
//   load     : take load_val (has priority over inc)
//   inc      : advance by one
//   load_val : branch destination
//   pc       : current program counter
// ----------------------------------------------------------------------------
module pc_reg #(
  parameter int                PC_W      = 8,
  parameter logic [PC_W-1:0]   RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;

  // Load beats increment; neither asserted means hold.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_seq.sv
// ----------------------------------------------------------------------------
// instr_fetch_seq
// Instruction fetch and sequencing stage. Owns the PC (via pc_reg) and the
// instruction register, runs RESET -> FETCH -> LOAD -> DECODE -> EXEC.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   instr_addr/instr_req: program memory read address (= pc) and request
//   instr_data          : memory read data, 1-cycle synchronous read
//   instr_valid         : read data valid, used only with IFU_WAIT_EN
//   stall               : hold in EXEC while downstream is busy
//   br_taken/br_target  : branch resolution, sampled when leaving EXEC
//   en_Fetch            : one-cycle strobe in DECODE, IR fields valid
//   en_Exec             : high for every EXEC cycle
//   I, RD_addr, operand : continuous slices of the instruction register
//   pc                  : current program counter
// Configuration macro:
//   IFU_WAIT_EN : LOAD waits for instr_valid, keeping instr_req high.
//                 Undefined (default): LOAD lasts exactly one cycle.
// ----------------------------------------------------------------------------
module instr_fetch_seq
  import risc_pkg::*;
#(
  parameter int              PC_W      = 8,
  parameter int              INSTR_W   = 16,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    instr_addr,
  output logic               instr_req,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               instr_valid,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic               en_Fetch,
  output logic               en_Exec,
  output logic [3:0]         I,
  output logic [4:0]         RD_addr,
  output logic [6:0]         operand,
  output logic [PC_W-1:0]    pc
);

  state_e               state_d, state_q;
  logic [INSTR_W-1:0]   ir_d, ir_q;
  logic                 instr_req_d, instr_req_q;
  logic                 en_fetch_d, en_fetch_q;
  logic                 en_exec_d, en_exec_q;
  logic                 pc_load;
  logic                 pc_inc;
  logic [PC_W-1:0]      pc_cur;

  pc_reg #(
    .PC_W      (PC_W),
    .RESET_VEC (RESET_VEC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (br_target),
    .pc       (pc_cur)
  );

`ifndef IFU_WAIT_EN
  logic unused_instr_valid;
  assign unused_instr_valid = instr_valid;
`endif

  // Next-state, IR capture and PC control. stall/br_taken only matter in
  // EXEC, and stall masks br_taken until the cycle it drops.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      ST_RESET:  state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_LOAD;
      ST_LOAD: begin
`ifdef IFU_WAIT_EN
        if (instr_valid) begin
          ir_d    = instr_data;
          state_d = ST_DECODE;
        end
`else
        ir_d    = instr_data;
        state_d = ST_DECODE;
`endif
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (!stall) begin
          pc_load = br_taken;
          pc_inc  = !br_taken;
          state_d = ST_FETCH;
        end
      end
      default:   state_d = ST_RESET;
    endcase
  end

  // Strobes are decoded from the next state so they come straight off flops
  // and line up with the state they describe.
  always_comb begin
`ifdef IFU_WAIT_EN
    instr_req_d = (state_d == ST_FETCH) || (state_d == ST_LOAD);
`else
    instr_req_d = (state_d == ST_FETCH);
`endif
    en_fetch_d  = (state_d == ST_DECODE);
    en_exec_d   = (state_d == ST_EXEC);
  end

  // Reset clears the IR, so an in-flight read is dropped and DECODE can
  // never be reached with a half-loaded instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RESET;
      ir_q        <= INSTR_W'(NOP_INSTR);
      instr_req_q <= 1'b0;
      en_fetch_q  <= 1'b0;
      en_exec_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      instr_req_q <= instr_req_d;
      en_fetch_q  <= en_fetch_d;
      en_exec_q   <= en_exec_d;
    end
  end

  assign instr_addr = pc_cur;
  assign pc         = pc_cur;
  assign instr_req  = instr_req_q;
  assign en_Fetch   = en_fetch_q;
  assign en_Exec    = en_exec_q;
  assign I          = ir_q[OPC_MSB:OPC_LSB];
  assign RD_addr    = ir_q[RD_MSB:RD_LSB];
  assign operand    = ir_q[OPND_MSB:OPND_LSB];

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Testbench for instr_fetch_seq (default build).
module tb_instr_fetch_seq;

   localparam logic [7:0] RVEC = 8'hFE;
   localparam int NUM_INSTR = 60;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  instr_addr;
   logic        instr_req;
   logic [15:0] instr_data = 16'h0;
   logic        instr_valid = 1'b0;
   logic        stall = 1'b0;
   logic        br_taken = 1'b0;
   logic [7:0]  br_target = 8'h0;
   logic        en_Fetch;
   logic        en_Exec;
   logic [3:0]  I;
   logic [4:0]  RD_addr;
   logic [6:0]  operand;
   logic [7:0]  pc;

   int errors = 0;
   int checks = 0;
   bit monEn = 1'b1;

   logic [15:0] mem [256];

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] instr;
      int          stalls;
      bit          br;
      logic [7:0]  tgt;
      logic [7:0]  nextPc;
   } item_t;

   item_t expQ[$];

   instr_fetch_seq #(
      .PC_W      (8),
      .INSTR_W   (16),
      .RESET_VEC (RVEC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_addr  (instr_addr),
      .instr_req   (instr_req),
      .instr_data  (instr_data),
      .instr_valid (instr_valid),
      .stall       (stall),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .en_Fetch    (en_Fetch),
      .en_Exec     (en_Exec),
      .I           (I),
      .RD_addr     (RD_addr),
      .operand     (operand),
      .pc          (pc)
   );

   // free-running clock
   always #5 clk = ~clk;

   // synchronous program memory: answers a request on the next cycle, and
   // puts noise on the bus otherwise so stray IR writes get noticed
   always @(posedge clk) begin
      if (instr_req) instr_data <= mem[instr_addr];
      else           instr_data <= 16'($urandom);
      instr_valid <= 1'b1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard monitor: pops one expected instruction per en_Fetch and
   // checks the end of its EXEC phase at the following FETCH
   initial begin
      item_t cur;
      bit haveCur = 1'b0;
      int execCnt = 0;
      int cyc = 0;
      forever begin
         @(negedge clk);
         if (!monEn || rst) begin
            haveCur = 1'b0;
            cyc = 0;
         end else begin
            cyc++;
            if (instr_req) begin
               if (haveCur) begin
                  checkOutput("exec_len", 32'(execCnt), 32'(cur.stalls + 1));
                  checkOutput("next_addr", 32'(instr_addr), 32'(cur.nextPc));
                  checkOutput("instr_period", 32'(cyc), 32'(4 + cur.stalls));
                  haveCur = 1'b0;
               end
               cyc = 0;
            end
            if (en_Fetch) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_fetch", 32'(1), 32'(0));
               end else begin
                  cur = expQ.pop_front();
                  haveCur = 1'b1;
                  execCnt = 0;
                  checkOutput("decode_pc", 32'(pc), 32'(cur.addr));
                  checkOutput("opcode", 32'(I), (32'(cur.instr) >> 12) & 32'hF);
                  checkOutput("rd_addr", 32'(RD_addr), (32'(cur.instr) >> 7) & 32'h1F);
                  checkOutput("operand", 32'(operand), 32'(cur.instr) & 32'h7F);
               end
            end
            if (en_Exec && haveCur) begin
               execCnt++;
               checkOutput("exec_pc_hold", 32'(pc), 32'(cur.addr));
            end
         end
      end
   end

   // noise on the EXEC-only inputs while the sequencer is elsewhere
   task automatic driveNoise();
      stall     = 1'($urandom);
      br_taken  = 1'($urandom);
      br_target = 8'($urandom);
   endtask

   // wait for EXEC of the current instruction, then drive its stall/branch
   task automatic applyStimulus(input item_t it);
      int guard = 0;
      @(negedge clk);
      while (!en_Exec && guard < 20) begin
         driveNoise();
         @(negedge clk);
         guard++;
      end
      if (!en_Exec) begin
         checkOutput("exec_timeout", 32'(0), 32'(1));
      end else begin
         for (int k = 0; k < it.stalls; k++) begin
            stall     = 1'b1;
            br_taken  = 1'($urandom);
            br_target = 8'($urandom);
            @(negedge clk);
         end
         stall     = 1'b0;
         br_taken  = it.br;
         br_target = it.tgt;
         @(negedge clk);
         driveNoise();
      end
   endtask

   initial begin
      item_t it;
      logic [7:0] modelPc;

      for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
      mem[0] = 16'h3A85;

      // reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_instr_req", 32'(instr_req), 32'(0));
      checkOutput("rst_en_fetch", 32'(en_Fetch), 32'(0));
      checkOutput("rst_en_exec", 32'(en_Exec), 32'(0));
      checkOutput("rst_ir", {17'(0), I, RD_addr, operand}, 32'(0));
      checkOutput("rst_pc", 32'(pc), 32'(RVEC));

      modelPc = RVEC;
      for (int i = 0; i < NUM_INSTR; i++) begin
         it.addr  = modelPc;
         it.instr = mem[modelPc];
         if (i < 3) begin
            it.stalls = 0; it.br = 1'b0; it.tgt = 8'h00;
         end else if (i == 3) begin
            it.stalls = 0; it.br = 1'b1; it.tgt = 8'h40;
         end else if (i == 4) begin
            it.stalls = 3; it.br = 1'b1; it.tgt = 8'h20;
         end else begin
            it.stalls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            it.br     = ($urandom_range(0, 2) == 0);
            it.tgt    = 8'($urandom);
         end
         it.nextPc = it.br ? it.tgt : 8'(modelPc + 8'd1);
         expQ.push_back(it);

         if (i == 0) begin
            // startup: FETCH one cycle after the RESET cycle, en_Fetch two later
            #1 rst = 1'b0;
            @(negedge clk);
            checkOutput("first_req", 32'(instr_req), 32'(1));
            checkOutput("first_addr", 32'(instr_addr), 32'(RVEC));
            checkOutput("first_no_fetch", 32'(en_Fetch), 32'(0));
            @(negedge clk);
            checkOutput("load_no_fetch", 32'(en_Fetch), 32'(0));
         end
         applyStimulus(it);
         modelPc = it.nextPc;
      end

      // reset in the middle of LOAD
      #1 monEn = 1'b0;
      checkOutput("queue_drained", 32'(expQ.size()), 32'(0));
      @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_en_fetch", 32'(en_Fetch), 32'(0));
      checkOutput("midrst_instr_req", 32'(instr_req), 32'(0));
      checkOutput("midrst_ir", {17'(0), I, RD_addr, operand}, 32'(0));
      checkOutput("midrst_pc", 32'(pc), 32'(RVEC));
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("restart_req", 32'(instr_req), 32'(1));
      checkOutput("restart_addr", 32'(instr_addr), 32'(RVEC));
      @(negedge clk);
      checkOutput("restart_load_no_fetch", 32'(en_Fetch), 32'(0));
      @(negedge clk);
      checkOutput("restart_decode", 32'(en_Fetch), 32'(1));
      checkOutput("restart_opcode", 32'(I), (32'(mem[RVEC]) >> 12) & 32'hF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch_seq.md
# instr_fetch_seq

Instruction fetch and sequencing stage of the 8-bit RISC core.
- Owns the program counter and instruction register (IR).
- Requests instructions from program memory and latches them.
- Runs the fetch/decode/execute cycle and generates the `en_Fetch` strobe.
- Drives the IR fields (`I` opcode, `RD_addr`) into the destination-address MSB generator and the decode logic directly downstream.

## Interface
Parameters:
- `PC_W`, 8, program counter / instruction address width
- `INSTR_W`, 16, instruction width; fields fixed below
- `RESET_VEC`, 0, PC value after reset

Ports:
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: reset, synchronous, active-high
- `instr_addr` out PC_W: program memory address (= PC)
- `instr_req` out 1: memory read request
- `instr_data` in INSTR_W: memory read data
- `instr_valid` in 1: read data valid (used only with `IFU_WAIT_EN`)
- `stall` in 1: hold in EXEC (downstream busy)
- `br_taken` in 1: branch resolved taken, sampled in EXEC
- `br_target` in PC_W: branch destination
- `en_Fetch` out 1: IR fields valid for downstream capture
- `en_Exec` out 1: execute strobe
- `I` out 4: opcode, IR[15:12]
- `RD_addr` out 5: destination register, IR[11:7]
- `operand` out 7: IR[6:0]
- `pc` out PC_W: current PC

## Operation
- States:
  - RESET → FETCH → LOAD → DECODE → EXEC → FETCH.
  - `rst` forces RESET from any state.
- RESET:
  - Outputs idle.
  - Unconditionally advances to FETCH the next cycle.
- FETCH:
  - `instr_req`=1, `instr_addr`=`pc`.
  - Always advances to LOAD.
- LOAD:
  - IR <= `instr_data` at end of cycle.
  - Advances to DECODE.
- DECODE:
  - `en_Fetch`=1 for exactly one full cycle.
  - IR is stable across both clock edges of this cycle, so negedge-sampling consumers capture valid `I`/`RD_addr`.
- EXEC:
  - `en_Exec`=1.
  - If `stall`=1: stay in EXEC; PC and IR hold.
  - If `stall`=0: PC <= `br_taken` ? `br_target` : `pc`+1, then go to FETCH.
- PC arithmetic: modulo 2^PC_W; 0xFF+1 → 0x00, with no flag.
- IR is only written in LOAD. Outputs `I`, `RD_addr`, `operand` are continuous IR slices.
- `stall` and `br_taken` asserted together: stall wins. `br_taken`/`br_target` are sampled on the cycle `stall` drops.
- `stall` or `br_taken` outside EXEC: ignored.

## Timing
- Reset values:
  - state=RESET, `pc`=RESET_VEC, IR=0.
  - `instr_req`=0, `en_Fetch`=0, `en_Exec`=0.
  - `I`=0, `RD_addr`=0, `operand`=0.
- First `instr_req` occurs in the second cycle after `rst` deasserts.
- Throughput: 4 cycles per instruction without stalls. Each stall cycle adds 1.
- Memory is synchronous, 1-cycle read: data is presented in the cycle after `instr_req`.
- `en_Fetch` rises 2 cycles after `instr_req`.
- New PC is visible on `instr_addr` in the FETCH cycle immediately after EXEC.
- `rst` asserted mid-instruction:
  - Next cycle is RESET, the IR is cleared, and any in-flight memory read is discarded.
  - `en_Fetch` is never asserted with a partial IR.

## Configuration
- `IFU_WAIT_EN` defined:
  - LOAD waits until `instr_valid`=1; IR is written on that cycle.
  - `instr_req` stays high throughout LOAD while waiting.
  - `instr_valid` outside LOAD is ignored.
- `IFU_WAIT_EN` undefined:
  - `instr_valid` is unused.
  - LOAD lasts exactly one cycle.

## Structure
- Shared package `risc_pkg` holds:
  - state enum (RESET/FETCH/LOAD/DECODE/EXEC);
  - IR field bit positions (OPC 15:12, RD 11:7, OPND 6:0);
  - `NOP_INSTR`=16'h0000.
- One sub-module, `pc_reg`: PC register with load/increment/hold and wrap.
- Remainder (FSM, IR, output decode) lives in the top module.

## Test plan
- Reset release, memory returns 16'h3A85 at address 0 → `en_Fetch` pulses in cycle 4, `I`=4'h3, `RD_addr`=5'h15, `operand`=7'h05; `pc`=1 at next FETCH.
- 256 sequential instructions from `pc`=0xFF start (RESET_VEC=8'hFF) → `instr_addr` sequence FF, 00, 01; no glitch at wrap.
- EXEC with `br_taken`=1, `br_target`=8'h40 → next `instr_addr`=8'h40.
- `stall`=1 for 3 cycles with `br_taken`=1, target 8'h20, in EXEC → `en_Exec` held 4 cycles, `pc` unchanged until release, then 8'h20.
- `rst` pulsed during LOAD → state RESET, IR=0, no `en_Fetch` pulse; fetch restarts at RESET_VEC.
- `IFU_WAIT_EN` defined, `instr_valid` delayed 2 cycles → LOAD held 3 cycles, `instr_req` high throughout, IR captures data on the valid cycle only.
